fb_prog_loader: RTL and testbench

- Program loader for the FB-CPU memory bus; writes program/data words into the block RAM, the other end of the CPU's instruction-fetch path.
- Accepts a word stream over a valid/ready handshake and writes words to consecutive RAM addresses starting at a base address.
- Holds the CPU in reset while loading, then releases it.
- Sits between an external source (UART/bench) and a RAM-port mux in front of blram.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_prog_loader_if.sv | 27 ++
 rtl/fb_loader_ptr.sv | 32 +++
 rtl/fb_prog_loader.sv | 179 +++++++++++++++++
 tb/tb_fb_prog_loader.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared FB-CPU definitions: loader state encoding, default bus widths and CPU opcodes.
// Imported by the program loader and by fb_cpu.
package fb_pkg;

    localparam int FB_ADDRESS_WIDTH = 6;
    localparam int FB_DATA_WIDTH    = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } fb_state_t;

    localparam logic [3:0] OP_LOD = 4'd0;
    localparam logic [3:0] OP_STO = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_DIV = 4'd5;
    localparam logic [3:0] OP_JMP = 4'd6;
    localparam logic [3:0] OP_JMZ = 4'd7;
    localparam logic [3:0] OP_HLT = 4'd9;

endpackage

// File: rtl/fb_prog_loader_if.sv
// Loader bus bundle: word stream in (valid/ready/last) and RAM port out (addr/data/we, 1-cycle read data).
// master = stream source + RAM side, slave = the loader.
interface fb_prog_loader_if
    import fb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = FB_DATA_WIDTH
);
    logic                     i_word_valid;
    logic [DATA_WIDTH-1:0]    i_word_data;
    logic                     i_word_last;
    logic                     o_word_ready;
    logic [ADDRESS_WIDTH-1:0] o_ram_addr;
    logic [DATA_WIDTH-1:0]    o_ram_data;
    logic                     o_ram_we;
    logic [DATA_WIDTH-1:0]    i_ram_data;

    modport master (
        output i_word_valid, i_word_data, i_word_last, i_ram_data,
        input  o_word_ready, o_ram_addr, o_ram_data, o_ram_we
    );

    modport slave (
        input  i_word_valid, i_word_data, i_word_last, i_ram_data,
        output o_word_ready, o_ram_addr, o_ram_data, o_ram_we
    );
endinterface

// File: rtl/fb_loader_ptr.sv
// Write pointer (wraps at 2**ADDRESS_WIDTH) and per-session word counter with full flag.
// Updates one cycle after load/inc; full is combinational from the registered count.
module fb_loader_ptr #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DEPTH         = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [ADDRESS_WIDTH-1:0] base,
    input  logic                     inc,
    output logic [ADDRESS_WIDTH-1:0] ptr,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     full
);
    localparam logic [ADDRESS_WIDTH:0] FULL_COUNT = (ADDRESS_WIDTH+1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (load) begin
            ptr   <= base;
            count <= '0;
        end else if (inc) begin
            ptr   <= ptr + ADDRESS_WIDTH'(1);
            count <= count + (ADDRESS_WIDTH+1)'(1);
        end
    end

    assign full = (count == FULL_COUNT);
endmodule

// File: rtl/fb_prog_loader.sv
// Program loader: streams words into block RAM from i_base, holding fb_cpu in reset until done; write lands 1 cycle after handshake.
// o_word_ready only in LOAD; optional read-back checksum with FB_LOADER_VERIFY_EN (adds o_count+2 cycles).
module fb_prog_loader
    import fb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = FB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = FB_DATA_WIDTH,
    parameter int DEPTH         = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [ADDRESS_WIDTH-1:0] i_base,
    fb_prog_loader_if.slave          bus,
    output logic                     o_cpu_rst,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_error,
    output logic [ADDRESS_WIDTH:0]   o_count
);
    fb_state_t                state, state_nx;
    logic                     ready_nx, we_nx, busy_nx, done_nx, error_nx, cpu_rst_nx;
    logic [ADDRESS_WIDTH-1:0] addr_nx;
    logic [DATA_WIDTH-1:0]    data_nx;
    logic                     ptr_load, ptr_inc, ptr_full;
    logic [ADDRESS_WIDTH-1:0] ptr;
    logic                     xfer;

    assign xfer = bus.i_word_valid && bus.o_word_ready;

    fb_loader_ptr #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DEPTH         (DEPTH)
    ) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .load  (ptr_load),
        .base  (i_base),
        .inc   (ptr_inc),
        .ptr   (ptr),
        .count (o_count),
        .full  (ptr_full)
    );

`ifdef FB_LOADER_VERIFY_EN
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [ADDRESS_WIDTH:0]   rd_idx;
    logic [1:0]               rd_pipe;
    logic [DATA_WIDTH-1:0]    wr_xor, rd_xor;
    logic                     rd_issue, rd_final, sum_ok;

    // rd_pipe[1] marks cycles where i_ram_data belongs to an issued read (addr reg + RAM reg)
    assign rd_issue = (state == ST_VERIFY) && (rd_idx != o_count);
    assign rd_final = (state == ST_VERIFY) && !rd_issue && (rd_pipe == 2'b10);
    assign sum_ok   = ((rd_xor ^ bus.i_ram_data) == wr_xor);

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            rd_idx  <= '0;
            rd_pipe <= '0;
            wr_xor  <= '0;
            rd_xor  <= '0;
        end else if (ptr_load) begin
            base_q  <= i_base;
            rd_idx  <= '0;
            rd_pipe <= '0;
            wr_xor  <= '0;
            rd_xor  <= '0;
        end else begin
            if (we_nx)
                wr_xor <= wr_xor ^ bus.i_word_data;
            if (rd_issue)
                rd_idx <= rd_idx + (ADDRESS_WIDTH+1)'(1);
            rd_pipe <= {rd_pipe[0], rd_issue};
            if (rd_pipe[1])
                rd_xor <= rd_xor ^ bus.i_ram_data;
        end
    end
`else
    logic unused_ram_data;
    assign unused_ram_data = ^bus.i_ram_data;
`endif

    always_comb begin
        state_nx   = state;
        ready_nx   = 1'b0;
        we_nx      = 1'b0;
        addr_nx    = bus.o_ram_addr;
        data_nx    = bus.o_ram_data;
        busy_nx    = o_busy;
        done_nx    = 1'b0;
        error_nx   = o_error;
        cpu_rst_nx = o_cpu_rst;
        ptr_load   = 1'b0;
        ptr_inc    = 1'b0;

        case (state)
            ST_IDLE, ST_ERROR: begin
                if (i_start) begin
                    ptr_load   = 1'b1;
                    error_nx   = 1'b0;
                    cpu_rst_nx = 1'b1;
                    busy_nx    = 1'b1;
                    state_nx   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    if (ptr_full) begin
                        error_nx = 1'b1;
                        busy_nx  = 1'b0;
                        state_nx = ST_ERROR;
                    end else begin
                        we_nx   = 1'b1;
                        addr_nx = ptr;
                        data_nx = bus.i_word_data;
                        ptr_inc = 1'b1;
                        if (bus.i_word_last) begin
`ifdef FB_LOADER_VERIFY_EN
                            state_nx = ST_VERIFY;
`else
                            state_nx   = ST_FINISH;
                            busy_nx    = 1'b0;
                            done_nx    = 1'b1;
                            cpu_rst_nx = 1'b0;
`endif
                        end
                    end
                end
            end
`ifdef FB_LOADER_VERIFY_EN
            ST_VERIFY: begin
                if (rd_issue)
                    addr_nx = base_q + rd_idx[ADDRESS_WIDTH-1:0];
                if (rd_final) begin
                    busy_nx = 1'b0;
                    if (sum_ok) begin
                        state_nx   = ST_FINISH;
                        done_nx    = 1'b1;
                        cpu_rst_nx = 1'b0;
                    end else begin
                        state_nx = ST_ERROR;
                        error_nx = 1'b1;
                    end
                end
            end
`endif
            ST_FINISH: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase

        ready_nx = (state_nx == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            bus.o_word_ready <= 1'b0;
            bus.o_ram_we     <= 1'b0;
            bus.o_ram_addr   <= '0;
            bus.o_ram_data   <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_error          <= 1'b0;
            o_cpu_rst        <= 1'b1;
        end else begin
            state            <= state_nx;
            bus.o_word_ready <= ready_nx;
            bus.o_ram_we     <= we_nx;
            bus.o_ram_addr   <= addr_nx;
            bus.o_ram_data   <= data_nx;
            o_busy           <= busy_nx;
            o_done           <= done_nx;
            o_error          <= error_nx;
            o_cpu_rst        <= cpu_rst_nx;
        end
    end
endmodule

// File: tb/tb_fb_prog_loader.sv
// Scoreboard bench for fb_prog_loader (DEPTH=4): expected RAM writes and o_done cycles are queued at handshake time.
// Define FB_LOADER_VERIFY_EN for the read-back build.
module tb_fb_prog_loader;
    localparam int AW    = 6;
    localparam int DW    = 10;
    localparam int DEPTH = 4;
`ifdef FB_LOADER_VERIFY_EN
    localparam bit VERIFY_ON = 1'b1;
`else
    localparam bit VERIFY_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_base = '0;
    logic          o_cpu_rst, o_busy, o_done, o_error;
    logic [AW:0]   o_count;

    fb_prog_loader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    fb_prog_loader #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_base    (i_base),
        .bus       (bus),
        .o_cpu_rst (o_cpu_rst),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_error   (o_error),
        .o_count   (o_count)
    );

    always #5 clk = ~clk;

    // block RAM model with registered read, plus a back door to corrupt one word
    logic [DW-1:0] ram [0:63];
    logic          corrupt = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    logic [DW-1:0] corrupt_val = '0;
    always @(posedge clk) begin
        if (bus.o_ram_we) ram[bus.o_ram_addr] <= bus.o_ram_data;
        if (corrupt) ram[corrupt_addr] <= corrupt_val;
        bus.i_ram_data <= ram[bus.o_ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            c;
    } wr_t;
    wr_t wq[$];
    int  dq[$];

    logic [AW-1:0] e_ptr;
    int            e_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        int  dc;
        if (bus.o_ram_we) begin
            if (wq.size() == 0) chk("spurious_we", {31'd0, bus.o_ram_we}, 32'd0);
            else begin
                e = wq.pop_front();
                chk("wr_addr", {26'd0, bus.o_ram_addr}, {26'd0, e.a});
                chk("wr_data", {22'd0, bus.o_ram_data}, {22'd0, e.d});
                chk("wr_cycle", cyc, e.c);
            end
        end
        if (o_done) begin
            if (dq.size() == 0) chk("spurious_done", {31'd0, o_done}, 32'd0);
            else begin
                dc = dq.pop_front();
                chk("done_cycle", cyc, dc);
            end
        end
    end

    task automatic reset_checks(input string p);
        chk({p, "_ready"},   {31'd0, bus.o_word_ready}, 32'd0);
        chk({p, "_we"},      {31'd0, bus.o_ram_we}, 32'd0);
        chk({p, "_addr"},    {26'd0, bus.o_ram_addr}, 32'd0);
        chk({p, "_data"},    {22'd0, bus.o_ram_data}, 32'd0);
        chk({p, "_cpu_rst"}, {31'd0, o_cpu_rst}, 32'd1);
        chk({p, "_busy"},    {31'd0, o_busy}, 32'd0);
        chk({p, "_done"},    {31'd0, o_done}, 32'd0);
        chk({p, "_error"},   {31'd0, o_error}, 32'd0);
        chk({p, "_count"},   {25'd0, o_count}, 32'd0);
    endtask

    task automatic begin_session(input logic [AW-1:0] b);
        i_start = 1'b1;
        i_base  = b;
        @(negedge clk);
        i_start = 1'b0;
        e_ptr   = b;
        e_cnt   = 0;
        chk("start_busy",    {31'd0, o_busy}, 32'd1);
        chk("start_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        chk("start_error",   {31'd0, o_error}, 32'd0);
        chk("start_count",   {25'd0, o_count}, 32'd0);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, input bit exp_done);
        int w;
        w = 0;
        bus.i_word_valid = 1'b1;
        bus.i_word_data  = d;
        bus.i_word_last  = last;
        while (!bus.o_word_ready && w < 16) begin
            @(negedge clk);
            w++;
        end
        if (!bus.o_word_ready) chk("ready_timeout", {31'd0, bus.o_word_ready}, 32'd1);
        else if (e_cnt < DEPTH) begin
            wq.push_back('{a: e_ptr, d: d, c: cyc + 1});
            e_ptr = e_ptr + 6'd1;
            e_cnt++;
            if (last && exp_done) dq.push_back(cyc + 1 + (VERIFY_ON ? e_cnt + 2 : 0));
        end
        @(negedge clk);
    endtask

    task automatic idle();
        bus.i_word_valid = 1'b0;
        bus.i_word_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_not_busy();
        int w;
        w = 0;
        while (o_busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("busy_timeout", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_word_valid = 1'b0;
        bus.i_word_data  = '0;
        bus.i_word_last  = 1'b0;
        repeat (10) @(negedge clk);
        reset_checks("rst");
        rst = 1'b0;
        @(negedge clk);

        // stream offered while idle must be ignored
        bus.i_word_valid = 1'b1;
        bus.i_word_data  = 10'h155;
        repeat (3) @(negedge clk);
        chk("idle_ready", {31'd0, bus.o_word_ready}, 32'd0);
        idle();

        // session A: base 0, four words back to back
        begin_session(6'd0);
        send_word(10'h032, 1'b0, 1'b0);
        send_word(10'h0B3, 1'b0, 1'b0);
        send_word(10'h074, 1'b0, 1'b0);
        send_word(10'h240, 1'b1, 1'b1);
        idle();
        wait_not_busy();
        chk("A_count",   {25'd0, o_count}, 32'd4);
        chk("A_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
        chk("A_ram0", {22'd0, ram[0]}, 32'h032);
        chk("A_ram1", {22'd0, ram[1]}, 32'h0B3);
        chk("A_ram2", {22'd0, ram[2]}, 32'h074);
        chk("A_ram3", {22'd0, ram[3]}, 32'h240);

        // session B: base 50, two words
        begin_session(6'd50);
        send_word(10'h005, 1'b0, 1'b0);
        send_word(10'h00A, 1'b1, 1'b1);
        idle();
        wait_not_busy();
        chk("B_count",   {25'd0, o_count}, 32'd2);
        chk("B_cpu_rst", {31'd0, o_cpu_rst}, 32'd0);
        chk("B_ram50", {22'd0, ram[50]}, 32'h005);
        chk("B_ram51", {22'd0, ram[51]}, 32'h00A);

        // backpressure 1,0,1,1,0,1 at base 10; a start pulse in the first gap is ignored
        begin_session(6'd10);
        send_word(10'h111, 1'b0, 1'b0);
        bus.i_word_valid = 1'b0;
        i_start = 1'b1;
        i_base  = 6'd40;
        @(negedge clk);
        i_start = 1'b0;
        send_word(10'h122, 1'b0, 1'b0);
        send_word(10'h133, 1'b0, 1'b0);
        idle();
        send_word(10'h144, 1'b1, 1'b1);
        idle();
        wait_not_busy();
        chk("BP_count", {25'd0, o_count}, 32'd4);
        chk("BP_ram13", {22'd0, ram[13]}, 32'h144);

        // pointer wrap from 63 to 0
        begin_session(6'd62);
        send_word(10'h3E1, 1'b0, 1'b0);
        send_word(10'h3E2, 1'b0, 1'b0);
        send_word(10'h3E3, 1'b1, 1'b1);
        idle();
        wait_not_busy();
        chk("W_count", {25'd0, o_count}, 32'd3);
        chk("W_ram62", {22'd0, ram[62]}, 32'h3E1);
        chk("W_ram63", {22'd0, ram[63]}, 32'h3E2);
        chk("W_ram0",  {22'd0, ram[0]},  32'h3E3);

        // overflow: fifth word with DEPTH=4 is dropped and flags an error
        begin_session(6'd20);
        send_word(10'h201, 1'b0, 1'b0);
        send_word(10'h202, 1'b0, 1'b0);
        send_word(10'h203, 1'b0, 1'b0);
        send_word(10'h204, 1'b0, 1'b0);
        send_word(10'h205, 1'b1, 1'b0);
        idle();
        chk("OV_error",   {31'd0, o_error}, 32'd1);
        chk("OV_busy",    {31'd0, o_busy}, 32'd0);
        chk("OV_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
        chk("OV_ready",   {31'd0, bus.o_word_ready}, 32'd0);
        chk("OV_count",   {25'd0, o_count}, 32'd4);

`ifdef FB_LOADER_VERIFY_EN
        // corrupt RAM[1] between its write and the read-back
        begin_session(6'd0);
        send_word(10'h101, 1'b0, 1'b0);
        send_word(10'h202, 1'b0, 1'b0);
        send_word(10'h303, 1'b0, 1'b0);
        send_word(10'h0C4, 1'b1, 1'b0);
        corrupt      = 1'b1;
        corrupt_addr = 6'd1;
        corrupt_val  = 10'h1FD;
        idle();
        corrupt = 1'b0;
        wait_not_busy();
        chk("VF_error",   {31'd0, o_error}, 32'd1);
        chk("VF_cpu_rst", {31'd0, o_cpu_rst}, 32'd1);
`endif

        // reset on the second handshake cycle: word not written, outputs back to reset values
        begin_session(6'd50);
        send_word(10'h111, 1'b0, 1'b0);
        bus.i_word_valid = 1'b1;
        bus.i_word_data  = 10'h222;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_word_valid = 1'b0;
        reset_checks("midrst");
        idle();
        idle();
        chk("RS_ram50", {22'd0, ram[50]}, 32'h111);
        chk("RS_ram51", {22'd0, ram[51]}, 32'h00A);

        chk("wq_left", wq.size(), 32'd0);
        chk("dq_left", dq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
